// File: rtl/decoder2to4_stream.sv
// Registered 2-to-4 one-hot decoder with a valid/ready stream interface,
// a two-entry skid buffer and per-line saturating hit counters.
module decoder2to4_stream #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_code,
  input  logic             in_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_y,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_out,
  input  logic             cnt_clr
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [3:0]       y_p0;
  logic [3:0]       y_p1;
  logic             vld_p1;
  logic [3:0]       y_p2;
  logic             vld_p2;
  logic [CNT_W-1:0] cnt [4];
  logic             accept;
  logic             handshake;

  // Stage 0: decode at accept time so buffered words are already one-hot
  assign y_p0      = in_en ? (4'b0001 << in_code) : 4'b0000;
  assign accept    = in_valid & in_ready;
  assign handshake = vld_p1 & out_ready;

  assign in_ready  = ~vld_p2;
  assign out_valid = vld_p1;
  assign out_y     = y_p1;
  assign cnt_out   = cnt[cnt_sel];

  // Stage 1 is the output register, stage 2 the skid register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p1   <= 4'b0000;
      vld_p1 <= 1'b0;
      y_p2   <= 4'b0000;
      vld_p2 <= 1'b0;
    end else if (!vld_p1 || handshake) begin
      if (vld_p2) begin
        // in_ready is low here, so no new word competes with the skid
        y_p1   <= y_p2;
        vld_p1 <= 1'b1;
        vld_p2 <= 1'b0;
      end else if (accept) begin
        y_p1   <= y_p0;
        vld_p1 <= 1'b1;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (accept) begin
      y_p2   <= y_p0;
      vld_p2 <= 1'b1;
    end
  end

  // Hit counters track words leaving the block; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else if (cnt_clr) begin
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else if (handshake) begin
      for (int k = 0; k < 4; k++)
        if (y_p1[k]) cnt[k] <= sat_inc(cnt[k]);
    end
  end

endmodule

// File: tb/tb_decoder2to4_stream.sv
// Bench for decoder2to4_stream: directed scenarios plus random traffic,
// checked against a queue-based reference of the stream and its counters.
module tb_decoder2to4_stream;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_code;
  logic             in_en;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_y;
  logic [1:0]       cnt_sel;
  logic [CNT_W-1:0] cnt_out;
  logic             cnt_clr;

  int total = 0;
  int bad   = 0;
  bit [3:0] q[$];
  int mcnt[4];

  always #5 clk = ~clk;

  decoder2to4_stream #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_en(in_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .cnt_sel(cnt_sel), .cnt_out(cnt_out), .cnt_clr(cnt_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check outputs against the model, advance the model.
  task automatic cycle(input bit v, input bit [1:0] code, input bit en,
                       input bit ordy, input bit clr, input bit [1:0] sel);
    bit hs, acc;
    bit [3:0] w;
    in_valid = v; in_code = code; in_en = en;
    out_ready = ordy; cnt_clr = clr; cnt_sel = sel;
    #1;
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) chk("out_y", out_y, q[0]);
    chk("onehot", $countones(out_y) <= 1, 1);
    chk("cnt_out", cnt_out, mcnt[sel]);
    hs  = (q.size() > 0) && ordy;
    acc = v && (q.size() < 2);
    if (hs) begin
      w = q.pop_front();
      for (int k = 0; k < 4; k++)
        if (w[k] && mcnt[k] < CMAX) mcnt[k]++;
    end
    if (clr) for (int k = 0; k < 4; k++) mcnt[k] = 0;
    if (acc) q.push_back(en ? (4'b0001 << code) : 4'b0000);
    @(negedge clk);
  endtask

  task automatic check_reset_state();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_in_ready", in_ready, 1);
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      #1;
      chk("rst_cnt", cnt_out, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_code = 0; in_en = 0; out_ready = 0; cnt_clr = 0; cnt_sel = 0;
    for (int k = 0; k < 4; k++) mcnt[k] = 0;
    #12;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;

    // Single transfer of code 2
    cycle(1, 2, 1, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 2);
    chk("single_y", out_y, 4'b0100);
    cycle(0, 0, 0, 1, 0, 2);
    cycle(0, 0, 0, 1, 0, 0);

    // Back-to-back stream 0..3
    for (int c = 0; c < 4; c++) cycle(1, 2'(c), 1, 1, 0, 2'(c));
    for (int c = 0; c < 4; c++) cycle(0, 0, 0, 1, 0, 2'(c));

    // Backpressure: 3 and 1 fill the buffer, 0 stalls
    cycle(1, 3, 1, 0, 0, 3);
    cycle(1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 0, 0);
    chk("bp_hold", out_y, 4'b1000);
    chk("bp_stall", in_ready, 0);
    for (int i = 0; i < 5; i++) cycle(i == 0, 0, 1, 1, 0, 2'(i));

    // Disabled decode
    cycle(1, 3, 0, 1, 0, 3);
    chk("dis_y", out_y, 4'b0000);
    chk("dis_vld", out_valid, 1);
    cycle(0, 0, 0, 1, 0, 3);

    // Saturation of counter 1, then clear colliding with a code-1 handshake
    cycle(0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 5; i++) cycle(1, 1, 1, 1, 0, 1);
    cycle(0, 0, 0, 1, 0, 1);
    cycle(0, 0, 0, 1, 0, 1);
    chk("sat_cnt1", cnt_out, CMAX);
    cycle(1, 1, 1, 1, 0, 1);
    cycle(0, 0, 0, 1, 1, 1);
    cycle(0, 0, 0, 1, 0, 1);
    chk("clr_cnt1", cnt_out, 0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 4) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0, 2'($urandom));

    // Reset while both entries are full
    cycle(1, 2, 1, 0, 0, 2);
    cycle(1, 3, 1, 0, 0, 3);
    chk("pre_rst_full", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state();
    q.delete();
    for (int k = 0; k < 4; k++) mcnt[k] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 0, 1, 1, 0, 0);
    chk("post_rst_y", out_y, 4'b0001);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
